// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one instruction-memory
// request at a time, buffers the returned instruction in a one-entry slot and
// hands it to IF/ID. Redirects (jump) from downstream override everything but
// reset. A redirect that arrives while a response is outstanding marks that
// response for discard.
//
// Handshakes:
//   imem side : a request transfers on a cycle with imem_req=1 and imem_gnt=1.
//               Exactly one response (imem_rvalid=1) follows, no earlier than
//               the next cycle. A response seen outside WAIT is ignored.
//   IF/ID side: the slot transfers on a cycle with valid_if=1 and
//               allow_in_id=1. ready_go_if is high whenever the slot is full.
//               valid_if drops in a jump cycle, so the slot is never delivered
//               together with a redirect.
module if_fetch #(
  parameter int unsigned           BUS_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [BUS_WIDTH-1:0]  PC_STEP    = BUS_WIDTH'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump,
  input  logic [BUS_WIDTH-1:0]  jump_addr,
  input  logic                  hold,
  output logic                  imem_req,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [BUS_WIDTH-1:0]  pc_if,
  output logic [DATA_WIDTH-1:0] instruction_if,
  output logic                  valid_if,
  output logic                  ready_go_if,
  input  logic                  allow_in_id,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  logic [1:0]            state;
  logic [BUS_WIDTH-1:0]  fetch_pc;
  logic [BUS_WIDTH-1:0]  slot_pc;
  logic [DATA_WIDTH-1:0] slot_instr;
  logic                  drop;

  // Outputs depend only on state, jump and hold; gnt and allow_in_id never
  // reach an output combinationally.
  always_comb begin
    imem_req       = (state == REQ) && !hold && !jump;
    imem_addr      = fetch_pc;
    ready_go_if    = (state == FULL);
    valid_if       = (state == FULL) && !jump;
    pc_if          = slot_pc;
    instruction_if = slot_instr;
    state_dbg      = state;
  end

  // Fetch FSM, PC and slot update; reset beats jump beats everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BOOT;
      fetch_pc   <= RESET_PC;
      slot_pc    <= '0;
      slot_instr <= '0;
      drop       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (jump) fetch_pc <= jump_addr;
          state <= REQ;
        end
        REQ: begin
          if (jump) begin
            fetch_pc <= jump_addr;
          end else if (imem_req && imem_gnt) begin
            slot_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + PC_STEP;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop || jump) begin
              // Response belongs to an abandoned path: throw it away.
              drop  <= 1'b0;
              state <= REQ;
              if (jump) fetch_pc <= jump_addr;
            end else begin
              slot_instr <= imem_rdata;
              state      <= FULL;
            end
          end else if (jump) begin
            // Remember to discard the response still in flight; the latest
            // target wins if several jumps arrive before it.
            drop     <= 1'b1;
            fetch_pc <= jump_addr;
          end
        end
        FULL: begin
          if (jump) begin
            fetch_pc <= jump_addr;
            state    <= REQ;
          end else if (allow_in_id) begin
            state <= REQ;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch. A behavioural instruction memory answers each
// grant with rdata = {16'hC0DE, addr[15:0]} after a programmable latency.
// Expected IF/ID handoffs are queued by the stimulus thread; a monitor pops
// and compares on every valid_if && allow_in_id cycle.
module tb_if_fetch;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FULL = 2'd3;

  logic        clk;
  logic        rst;
  logic        jump;
  logic [31:0] jump_addr;
  logic        hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_if;
  logic [31:0] instruction_if;
  logic        valid_if;
  logic        ready_go_if;
  logic        allow_in_id;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  logic [63:0] exp_q[$];

  if_fetch dut (
    .clk(clk), .rst(rst), .jump(jump), .jump_addr(jump_addr), .hold(hold),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_if(pc_if), .instruction_if(instruction_if), .valid_if(valid_if),
    .ready_go_if(ready_go_if), .allow_in_id(allow_in_id), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // Behavioural instruction memory: grant sampled at the edge, response
  // driven just after the edge lat cycles later.
  initial begin
    logic        g;
    logic [31:0] ga;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      g  = imem_req && imem_gnt;
      ga = imem_addr;
      #1;
      imem_rvalid = 1'b0;
      if (g) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = ga;
      end
      if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = {16'hC0DE, paddr[15:0]};
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: every IF/ID transfer must match the head of the expected queue.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (valid_if === 1'b1 && allow_in_id === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_handoff", {pc_if, instruction_if}, 64'hx);
        end else begin
          e = exp_q.pop_front();
          chk("handoff", {pc_if, instruction_if}, e);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    rst = 1'b1; jump = 1'b0; jump_addr = '0; hold = 1'b0;
    imem_gnt = 1'b1; allow_in_id = 1'b1;
    step(); step();
    chk("rst_req",      64'(imem_req),       64'd0);
    chk("rst_addr",     64'(imem_addr),      64'd0);
    chk("rst_pc_if",    64'(pc_if),          64'd0);
    chk("rst_instr",    64'(instruction_if), 64'd0);
    chk("rst_valid",    64'(valid_if),       64'd0);
    chk("rst_ready_go", 64'(ready_go_if),    64'd0);
    chk("rst_state",    64'(state_dbg),      64'(S_BOOT));
    rst = 1'b0;

    // Sequential fetch with zero-wait memory
    step();
    chk("seq_req0",  64'(imem_req),  64'd1);
    chk("seq_addr0", 64'(imem_addr), 64'h0);
    push(32'h0, 32'hC0DE0000);
    step();
    chk("seq_wait",     64'(state_dbg), 64'(S_WAIT));
    chk("seq_wait_req", 64'(imem_req),  64'd0);
    step();
    chk("seq_valid0", 64'(valid_if),    64'd1);
    chk("seq_rgo0",   64'(ready_go_if), 64'd1);
    step();
    chk("seq_addr4", 64'(imem_addr), 64'h4);
    chk("seq_req4",  64'(imem_req),  64'd1);
    push(32'h4, 32'hC0DE0004);
    step();
    allow_in_id = 1'b0;

    // Downstream stall with the pc=4 instruction in the slot
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 64'(valid_if),       64'd1);
      chk("stall_pc",    64'(pc_if),          64'h4);
      chk("stall_instr", 64'(instruction_if), 64'hC0DE0004);
      chk("stall_req",   64'(imem_req),       64'd0);
    end
    step();
    allow_in_id = 1'b1;
    step();
    chk("seq_addr8", 64'(imem_addr), 64'h8);
    chk("seq_req8",  64'(imem_req),  64'd1);
    push(32'h8, 32'hC0DE0008);
    step(); step(); step();
    chk("seq_addrC", 64'(imem_addr), 64'hC);
    chk("seq_reqC",  64'(imem_req),  64'd1);
    lat = 2;

    // Jumps while the response for 0xC is in flight; the last target wins
    step();
    jump = 1'b1; jump_addr = 32'h200;
    #1;
    chk("wjump_valid", 64'(valid_if), 64'd0);
    step();
    jump_addr = 32'h100;
    chk("wjump_state", 64'(state_dbg), 64'(S_WAIT));
    step();
    jump = 1'b0;
    #1;
    chk("wjump_drop_valid", 64'(valid_if), 64'd0);
    lat = 0;
    step();
    chk("wjump_req",  64'(imem_req),  64'd1);
    chk("wjump_addr", 64'(imem_addr), 64'h100);
    push(32'h100, 32'hC0DE0100);
    step(); step(); step();
    chk("seq_addr104", 64'(imem_addr), 64'h104);

    // Jump in FULL together with allow_in_id=1: the slot is not delivered
    step(); step();
    jump = 1'b1; jump_addr = 32'h300;
    #1;
    chk("fjump_valid", 64'(valid_if),    64'd0);
    chk("fjump_rgo",   64'(ready_go_if), 64'd1);
    step();
    jump = 1'b0;
    #1;
    chk("fjump_req",  64'(imem_req),  64'd1);
    chk("fjump_addr", 64'(imem_addr), 64'h300);

    // hold in REQ with gnt tied high
    hold = 1'b1;
    #1;
    chk("hold_req", 64'(imem_req), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_req",  64'(imem_req),  64'd0);
      chk("hold_addr", 64'(imem_addr), 64'h300);
    end
    step();
    hold = 1'b0;
    #1;
    chk("hold_resume_req",  64'(imem_req),  64'd1);
    chk("hold_resume_addr", 64'(imem_addr), 64'h300);
    push(32'h300, 32'hC0DE0300);
    step(); step(); step();
    chk("seq_addr304", 64'(imem_addr), 64'h304);

    // Jump in REQ to the top of the address space, then wrap
    jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    #1;
    chk("rjump_req", 64'(imem_req), 64'd0);
    step();
    jump = 1'b0;
    #1;
    chk("rjump_req2", 64'(imem_req),  64'd1);
    chk("rjump_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'hC0DEFFFC);
    step(); step(); step();
    chk("wrap_req",  64'(imem_req),  64'd1);
    chk("wrap_addr", 64'(imem_addr), 64'h0);
    lat = 2;

    // Reset while a response is outstanding; it arrives after reset
    step();
    chk("rstw_state", 64'(state_dbg), 64'(S_WAIT));
    rst = 1'b1; imem_gnt = 1'b0;
    step();
    chk("rstw_boot",  64'(state_dbg), 64'(S_BOOT));
    chk("rstw_req",   64'(imem_req),  64'd0);
    chk("rstw_valid", 64'(valid_if),  64'd0);
    chk("rstw_addr",  64'(imem_addr), 64'h0);
    chk("rstw_rgo",   64'(ready_go_if), 64'd0);
    rst = 1'b0;
    step();
    chk("rstw_req_state", 64'(state_dbg), 64'(S_REQ));
    chk("rstw_req1",      64'(imem_req),  64'd1);
    chk("rstw_addr1",     64'(imem_addr), 64'h0);
    chk("rstw_valid1",    64'(valid_if),  64'd0);
    step();
    chk("rstw_stale_state", 64'(state_dbg), 64'(S_REQ));
    chk("rstw_valid2",      64'(valid_if),  64'd0);
    lat = 0; imem_gnt = 1'b1;
    push(32'h0, 32'hC0DE0000);

    // Drain the expected queue with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
